// File: rtl/banner_sequencer_if.sv
// banner_sequencer_if: frame/start/abort controls in, banner selects and game timer out.
interface banner_sequencer_if;
   logic       frame_tick;
   logic       start;
   logic       abort;
   logic       get_ready;
   logic       times_up;
   logic       leaderboard;
   logic       playing;
   logic [6:0] secs_left;
   logic       sec_tick;
   modport master (
      output frame_tick, start, abort,
      input  get_ready, times_up, leaderboard, playing, secs_left, sec_tick
   );
   modport slave (
      input  frame_tick, start, abort,
      output get_ready, times_up, leaderboard, playing, secs_left, sec_tick
   );
endinterface

// File: rtl/banner_sequencer.sv
// banner_sequencer: get-ready -> timed play -> times-up -> leaderboard banner sequencing,
// counted in video frames.
module banner_sequencer #(
   parameter int FPS            = 60,
   parameter int READY_FRAMES   = 180,
   parameter int GAME_SECS      = 60,
   parameter int TIMESUP_FRAMES = 120
) (
   input logic                 clk,
   input logic                 resetn,
   banner_sequencer_if.slave   bus
);
   typedef enum logic [2:0] {IDLE, READY, PLAY, TIMESUP, BOARD} state_t;
   state_t     r_state, w_next;
   logic [9:0] r_frm, w_frm;
   logic [6:0] r_sub, w_sub;
   logic [6:0] r_secs, w_secs;
   logic       r_sec_tick, w_sec_tick;
   logic       r_get_ready, r_playing, r_times_up, r_leaderboard;
   logic       w_sec_wrap;
   assign w_sec_wrap = r_sub == 7'(FPS - 1);
   always_comb begin
      w_next     = r_state;
      w_frm      = r_frm;
      w_sub      = r_sub;
      w_secs     = r_secs;
      w_sec_tick = 1'b0;
      if (bus.abort && r_state != IDLE) begin
         w_next = IDLE;
         w_frm  = '0;
         w_sub  = '0;
         w_secs = '0;
      end else begin
         case (r_state)
            IDLE, BOARD: if (bus.start) begin
               w_next = READY;
               w_frm  = '0;
               w_secs = '0;
            end
            READY: if (bus.frame_tick) begin
               w_frm = r_frm + 10'd1;
               if (r_frm == 10'(READY_FRAMES - 1)) begin
                  w_next = PLAY;
                  w_frm  = '0;
                  w_sub  = '0;
                  w_secs = 7'(GAME_SECS);
               end
            end
            PLAY: if (bus.frame_tick) begin
               w_sub = w_sec_wrap ? 7'd0 : r_sub + 7'd1;
               if (w_sec_wrap) begin
                  w_secs     = (r_secs == 7'd0) ? 7'd0 : r_secs - 7'd1;
                  w_sec_tick = 1'b1;
                  // last second expiring hands straight over to the times-up banner
                  if (r_secs == 7'd1) begin
                     w_next = TIMESUP;
                     w_frm  = '0;
                  end
               end
            end
            TIMESUP: if (bus.frame_tick) begin
               w_frm = r_frm + 10'd1;
               if (r_frm == 10'(TIMESUP_FRAMES - 1)) w_next = BOARD;
            end
            default: w_next = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= IDLE;
         r_frm         <= '0;
         r_sub         <= '0;
         r_secs        <= '0;
         r_sec_tick    <= 1'b0;
         r_get_ready   <= 1'b0;
         r_playing     <= 1'b0;
         r_times_up    <= 1'b0;
         r_leaderboard <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_frm         <= w_frm;
         r_sub         <= w_sub;
         r_secs        <= w_secs;
         r_sec_tick    <= w_sec_tick;
         r_get_ready   <= w_next == READY;
         r_playing     <= w_next == PLAY;
         r_times_up    <= w_next == TIMESUP;
         r_leaderboard <= w_next == BOARD;
      end
   end
   assign bus.get_ready   = r_get_ready;
   assign bus.playing     = r_playing;
   assign bus.times_up    = r_times_up;
   assign bus.leaderboard = r_leaderboard;
   assign bus.secs_left   = r_secs;
   assign bus.sec_tick    = r_sec_tick;
endmodule
